// File: rtl/bridge_arbiter.sv
// rtl/bridge_arbiter.sv - two-master arbiter in front of the single peripheral bridge port
module bridge_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic [29:0] pr_addr,
  output logic [31:0] pr_wd,
  output logic        pr_we,
  output logic [3:0]  pr_be,
  input  logic [31:0] pr_rd
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t      state;
  logic        owner;
  logic        last;
  logic [29:0] held_addr;
  logic [31:0] held_wd;
  logic        held_we;
  logic [3:0]  held_be;
  logic        pick_m1;

  // Winner selection: a lone requester wins; on a tie either m0 (fixed) or the master not served last.
  always_comb begin
    pick_m1 = 1'b0;
    if (m0_req && m1_req) begin
      pick_m1 = (FIXED_PRIO != 0) ? 1'b0 : ~last;
    end else begin
      pick_m1 = m1_req;
    end
  end

  // Arbitration FSM: latch the winner, run one bridge cycle, pulse the owner's ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      held_addr <= '0;
      held_wd   <= '0;
      held_we   <= 1'b0;
      held_be   <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rd     <= '0;
      m1_rd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner     <= pick_m1;
            last      <= pick_m1;
            held_addr <= pick_m1 ? m1_addr : m0_addr;
            held_wd   <= pick_m1 ? m1_wd   : m0_wd;
            held_we   <= pick_m1 ? m1_we   : m0_we;
            held_be   <= pick_m1 ? m1_be   : m0_be;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (owner) begin
            m1_rd  <= pr_rd;
            m1_ack <= 1'b1;
          end else begin
            m0_rd  <= pr_rd;
            m0_ack <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          // Requests are stale here, so no arbitration until the next IDLE.
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The bridge always sees the hold registers; the write strobe is gated to GRANT and off during reset.
  assign pr_addr = held_addr;
  assign pr_wd   = held_wd;
  assign pr_be   = held_be;
  assign pr_we   = (state == GRANT) & held_we & ~reset;

endmodule

// File: doc/bridge_arbiter.md
# bridge_arbiter

Two-master arbiter that shares the single processor-side peripheral bridge port (timer0 at 0x0000_7F00, timer1 at 0x0000_7F10) between the CPU data-memory stage (m0) and a secondary bus master (m1, DMA/loader). It latches each winning request, drives exactly one bridge access, and returns the read data and a registered acknowledge. It sits between the masters and the bridge, and the bridge is unchanged.

## Interface
Parameters:
- FIXED_PRIO, default 0. 0 = round-robin between m0 and m1; 1 = m0 always wins ties.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  request; held high until the matching ack.
- m0_addr / m1_addr  in  30  word address [31:2].
- m0_wd / m1_wd  in  32  write data.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_be / m1_be  in  4  byte enables.
- m0_ack / m1_ack  out  1  one-cycle completion pulse, registered.
- m0_rd / m1_rd  out  32  read data, valid while ack is high, then held.
- pr_addr  out  30  to the bridge PrAddr.
- pr_wd  out  32  to the bridge PrWD.
- pr_we  out  1  to the bridge PrWe.
- pr_be  out  4  to the bridge PrBE.
- pr_rd  in  32  from the bridge PrRD, combinational.

## Operation
- State machine: IDLE -> GRANT -> DONE -> IDLE. Transitions are unconditional except the IDLE exit.
- IDLE, no request pending: the state stays IDLE.
- IDLE, exactly one request pending: that master wins.
- IDLE, both requests pending:
  - FIXED_PRIO=1: m0 wins.
  - FIXED_PRIO=0: the master that is not `last` wins.
- On an IDLE exit:
  - Latch the winner's addr, wd, we and be into the hold registers.
  - Set `owner` to the winner and update `last` to the winner.
  - Go to GRANT.
- GRANT, one cycle:
  - pr_addr, pr_wd and pr_be come from the hold registers.
  - pr_we = held_we & ~reset.
  - At the end of the cycle, pr_rd is registered into owner_rd and owner_ack is set.
- DONE, one cycle:
  - owner_ack = 1 and pr_we = 0.
  - The master drops req during this cycle.
  - No arbitration happens here, because a stale req is still visible.
- Outside GRANT, pr_addr, pr_wd and pr_be keep the hold-register values and pr_we = 0.
- The request fields are buffered, so a master that changes addr/wd or drops req after it has been granted does not affect the access in flight.
- The non-owner's rd and ack are never touched.
- Throughput: one access per 3 cycles. Strict alternation whenever both masters request continuously (FIXED_PRIO=0).
- Reset values:
  - State: IDLE.
  - owner = 0, last = 1, so m0 wins the first tie.
  - Hold registers = 0.
  - m0_ack = m1_ack = 0.
  - m0_rd = m1_rd = 0.
  - pr_we = 0, pr_addr = 0, pr_wd = 0, pr_be = 0.
- Reset mid-transaction:
  - Any state returns to IDLE and no ack is issued.
  - A reset asserted during GRANT suppresses pr_we in that cycle, so no write reaches a timer.

## Timing
- Cycle N: req is high in IDLE.
- Cycle N+1: GRANT; the bridge access happens and pr_we is high for writes.
- Cycle N+2: DONE; ack = 1 and rd is valid.
- Cycle N+3: IDLE; the earliest next grant is at N+4.
- Latency from req to ack is 2 cycles when uncontended.
- A loser waits at most one full transaction (3 cycles) under round-robin.
- pr_we is high for exactly one cycle per write. It is never high on reads, in IDLE, in DONE, or during reset.

## Test plan
- Reset, then idle: hold reset high for 2 cycles -> all outputs 0; state IDLE; no ack for 10 idle cycles.
- m0 single write:
  - Stimulus: m0 writes addr 0x1FC0 (timer0 ctrl), wd 0x0000_0009, be 0xF.
  - Required: in cycle N+1, pr_addr = 0x1FC0, pr_wd = 0x9, pr_we = 1 for exactly 1 cycle.
  - Required: in cycle N+2, m0_ack = 1.
- m1 read:
  - Stimulus: m1 reads addr 0x1FC5 (timer1 count) with pr_rd = 0xDEAD_BEEF.
  - Required: m1_ack at N+2, m1_rd = 0xDEAD_BEEF, pr_we stays 0.
  - Required: m0_rd and m0_ack are unchanged.
- Simultaneous requests, FIXED_PRIO=0, both held:
  - Required: grants follow m0, m1, m0, m1, with acks at cycles 2, 5, 8, 11 after the first req.
  - With FIXED_PRIO=1 and m0 held continuously, m0 is served every transaction.
- Buffering: m0 is granted, then addr changes to 0x1FC4 during GRANT -> pr_addr still shows the latched 0x1FC0.
- Reset during GRANT of an m1 write -> pr_we = 0 that cycle; no m1_ack; state IDLE next cycle; the following m0 request is served normally.
